// File: rtl/avg_pkg.sv
// Shared types for the averaged-sample crossing detector.
package avg_pkg;

  localparam int DATA_W = 8;
  localparam int TS_W   = 16;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    RISE_PEND = 2'd1,
    HIGH      = 2'd2,
    FALL_PEND = 2'd3
  } state_t;

  typedef struct packed {
    logic            rising;
    logic [TS_W-1:0] ts;
  } evt_t;

endpackage

// File: rtl/avg_crossing_detector_if.sv
// Sample input and event output bundle of the crossing detector.
// evt_ts_o and TS_W exist only when AVG_EVT_TIMESTAMP_EN is defined.
interface avg_crossing_detector_if #(
  parameter int DATA_W = avg_pkg::DATA_W
`ifdef AVG_EVT_TIMESTAMP_EN
  , parameter int TS_W = avg_pkg::TS_W
`endif
);
  logic signed [DATA_W-1:0] sample_i;
  logic                     sample_valid_i;
  logic signed [DATA_W-1:0] thr_hi_i;
  logic signed [DATA_W-1:0] thr_lo_i;
  logic                     evt_valid_o;
  logic                     evt_ready_i;
  logic                     evt_rising_o;
  logic                     overflow_o;
  logic                     level_o;
`ifdef AVG_EVT_TIMESTAMP_EN
  logic [TS_W-1:0]          evt_ts_o;
`endif

  modport master (
    output sample_i, sample_valid_i, thr_hi_i, thr_lo_i, evt_ready_i,
    input  evt_valid_o, evt_rising_o, overflow_o, level_o
`ifdef AVG_EVT_TIMESTAMP_EN
    , input evt_ts_o
`endif
  );

  modport slave (
    input  sample_i, sample_valid_i, thr_hi_i, thr_lo_i, evt_ready_i,
    output evt_valid_o, evt_rising_o, overflow_o, level_o
`ifdef AVG_EVT_TIMESTAMP_EN
    , output evt_ts_o
`endif
  );

endinterface

// File: rtl/avg_evt_slot.sv
// One-entry valid/ready event register; a push into a full, stalled slot is
// dropped and raises a sticky overflow flag.
module avg_evt_slot #(
  parameter int PAYLOAD_W = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [PAYLOAD_W-1:0] payload,
  input  logic                 ready,
  output logic                 valid,
  output logic [PAYLOAD_W-1:0] data,
  output logic                 overflow
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= 1'b0;
      data     <= '0;
      overflow <= 1'b0;
    end else if (push) begin
      // A consumer taking the old entry this cycle frees room for the new one.
      if (!valid || ready) begin
        valid <= 1'b1;
        data  <= payload;
      end else begin
        overflow <= 1'b1;
      end
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/avg_crossing_detector.sv
// Debounced hysteresis crossing detector feeding a one-entry event slot.
// Define AVG_EVT_TIMESTAMP_EN to add a sample-index timestamp to each event.
module avg_crossing_detector #(
  parameter int DATA_W      = avg_pkg::DATA_W,
  parameter int HOLD_CYCLES = 4,
  parameter int TS_W        = avg_pkg::TS_W
) (
  input  logic                    system1000,
  input  logic                    system1000_rst,
  avg_crossing_detector_if.slave  io
);
  import avg_pkg::*;

  // state     | meaning
  // LOW       | committed low, waiting for a sample above thr_hi
  // RISE_PEND | counting consecutive above samples toward a rising commit
  // HIGH      | committed high, waiting for a sample below thr_lo
  // FALL_PEND | counting consecutive below samples toward a falling commit

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  if (HOLD_CYCLES < 1 || TS_W < 1) begin : g_param_check
    $error("avg_crossing_detector: HOLD_CYCLES and TS_W must be >= 1");
  end

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             level;
  logic             above;
  logic             below;
  logic             hit_rise;
  logic             hit_fall;

  assign above   = $signed(io.sample_i) > $signed(io.thr_hi_i);
  assign below   = $signed(io.sample_i) < $signed(io.thr_lo_i);
  assign cnt_inc = (cnt == HOLD_CNT) ? cnt : cnt + ONE_CNT;

  always_comb begin
    hit_rise = 1'b0;
    hit_fall = 1'b0;
    if (io.sample_valid_i) begin
      case (state)
        LOW:       hit_rise = above && (HOLD_CYCLES == 1);
        RISE_PEND: hit_rise = above && (cnt_inc == HOLD_CNT);
        HIGH:      hit_fall = below && (HOLD_CYCLES == 1);
        FALL_PEND: hit_fall = below && (cnt_inc == HOLD_CNT);
        default:   ;
      endcase
    end
  end

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      state <= LOW;
      cnt   <= '0;
      level <= 1'b0;
    end else if (io.sample_valid_i) begin
      case (state)
        LOW: begin
          if (hit_rise) begin
            state <= HIGH;
            cnt   <= '0;
            level <= 1'b1;
          end else if (above) begin
            state <= RISE_PEND;
            cnt   <= ONE_CNT;
          end
        end
        RISE_PEND: begin
          if (hit_rise) begin
            state <= HIGH;
            cnt   <= '0;
            level <= 1'b1;
          end else if (above) begin
            cnt <= cnt_inc;
          end else begin
            state <= LOW;
            cnt   <= '0;
          end
        end
        HIGH: begin
          if (hit_fall) begin
            state <= LOW;
            cnt   <= '0;
            level <= 1'b0;
          end else if (below) begin
            state <= FALL_PEND;
            cnt   <= ONE_CNT;
          end
        end
        FALL_PEND: begin
          if (hit_fall) begin
            state <= LOW;
            cnt   <= '0;
            level <= 1'b0;
          end else if (below) begin
            cnt <= cnt_inc;
          end else begin
            state <= HIGH;
            cnt   <= '0;
          end
        end
        default: begin
          state <= LOW;
          cnt   <= '0;
          level <= 1'b0;
        end
      endcase
    end
  end

`ifdef AVG_EVT_TIMESTAMP_EN
  localparam int PAYLOAD_W = 1 + TS_W;
  logic [TS_W-1:0] ts_cnt;

  always_ff @(posedge system1000) begin
    if (system1000_rst) ts_cnt <= '0;
    else if (io.sample_valid_i) ts_cnt <= ts_cnt + TS_W'(1);
  end
`else
  localparam int PAYLOAD_W = 1;
`endif

  logic [PAYLOAD_W-1:0] payload;
  logic [PAYLOAD_W-1:0] slot_data;
  logic                 slot_valid;
  logic                 slot_ovf;

`ifdef AVG_EVT_TIMESTAMP_EN
  assign payload = {hit_rise, ts_cnt};
`else
  assign payload = hit_rise;
`endif

  avg_evt_slot #(
    .PAYLOAD_W (PAYLOAD_W)
  ) u_slot (
    .clk      (system1000),
    .rst      (system1000_rst),
    .push     (hit_rise | hit_fall),
    .payload  (payload),
    .ready    (io.evt_ready_i),
    .valid    (slot_valid),
    .data     (slot_data),
    .overflow (slot_ovf)
  );

  assign io.evt_valid_o  = slot_valid;
  assign io.evt_rising_o = slot_data[PAYLOAD_W-1];
  assign io.overflow_o   = slot_ovf;
  assign io.level_o      = level;
`ifdef AVG_EVT_TIMESTAMP_EN
  assign io.evt_ts_o     = slot_data[TS_W-1:0];
`endif

endmodule

// File: tb/tb_avg_crossing_detector.sv
// Directed vector bench for avg_crossing_detector (HOLD_CYCLES=4, thr 20/-20).
module tb_avg_crossing_detector;

  typedef struct {
    logic              v;
    logic signed [7:0] s;
    logic              r;
    logic              rst;
    logic              ev;
    logic              cr;
    logic              er;
    logic              eo;
    logic              el;
    int                ets;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t tbl[$];

  avg_crossing_detector_if bus ();

  avg_crossing_detector #(
    .DATA_W      (8),
    .HOLD_CYCLES (4),
    .TS_W        (16)
  ) dut (
    .system1000     (clk),
    .system1000_rst (rst),
    .io             (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input string tag);
    bus.sample_valid_i = t.v;
    bus.sample_i       = t.s;
    bus.evt_ready_i    = t.r;
    rst                = t.rst;
    @(posedge clk);
    #1;
    check({tag, " evt_valid"}, bus.evt_valid_o, t.ev);
    if (t.cr) check({tag, " evt_rising"}, bus.evt_rising_o, t.er);
    check({tag, " overflow"}, bus.overflow_o, t.eo);
    check({tag, " level"}, bus.level_o, t.el);
`ifdef AVG_EVT_TIMESTAMP_EN
    if (t.ets >= 0) begin
      n_checks++;
      if (int'(bus.evt_ts_o) != t.ets) begin
        n_fail++;
        $display("FAIL %s evt_ts: got %0d expected %0d", tag, bus.evt_ts_o, t.ets);
      end
    end
`endif
  endtask

  function automatic vec_t mk(input logic v, input int s, input logic r, input logic rs,
                              input logic ev, input logic cr, input logic er,
                              input logic eo, input logic el, input int ets);
    vec_t t;
    t.v = v; t.s = s[7:0]; t.r = r; t.rst = rs;
    t.ev = ev; t.cr = cr; t.er = er; t.eo = eo; t.el = el; t.ets = ets;
    return t;
  endfunction

  task automatic addn(input int n, input logic v, input int s, input logic r, input logic rs,
                      input logic ev, input logic cr, input logic er,
                      input logic eo, input logic el, input int ets = -1);
    for (int k = 0; k < n; k++) tbl.push_back(mk(v, s, r, rs, ev, cr, er, eo, el, ets));
  endtask

  task automatic cyc(input string tag, input logic v, input int s, input logic r, input logic rs,
                     input logic ev, input logic cr, input logic er,
                     input logic eo, input logic el, input int ets = -1);
    apply(mk(v, s, r, rs, ev, cr, er, eo, el, ets), tag);
  endtask

  initial begin
    bus.thr_hi_i       = 8'sd20;
    bus.thr_lo_i       = -8'sd20;
    bus.sample_i       = '0;
    bus.sample_valid_i = 1'b0;
    bus.evt_ready_i    = 1'b1;

    //   n  v  smp  r rst  ev cr er eo el
    addn(1, 0,   0, 1, 1,  0, 1, 0, 0, 0);             // reset values
    addn(3, 1,  25, 1, 0,  0, 0, 0, 0, 0);             // rise pending
    addn(1, 1,  25, 1, 0,  1, 1, 1, 0, 1, 3);          // 4th sample commits rise
    addn(1, 0,   0, 1, 0,  0, 0, 0, 0, 1);             // consumed
    addn(2, 1, -20, 1, 0,  0, 0, 0, 0, 1);             // exactly thr_lo: no effect
    addn(3, 1, -25, 1, 0,  0, 0, 0, 0, 1);
    addn(1, 1, -25, 1, 0,  1, 1, 0, 0, 0);             // fall commits
    addn(1, 0,   0, 1, 0,  0, 0, 0, 0, 0);
    addn(2, 1,  20, 1, 0,  0, 0, 0, 0, 0);             // exactly thr_hi: no effect
    addn(3, 1,  25, 1, 0,  0, 0, 0, 0, 0);
    addn(1, 1,  10, 1, 0,  0, 0, 0, 0, 0);             // abort back to LOW
    addn(3, 1,  25, 1, 0,  0, 0, 0, 0, 0);             // cnt restarts at 1
    addn(1, 1,  25, 1, 0,  1, 1, 1, 0, 1);
    addn(1, 0,   0, 1, 0,  0, 0, 0, 0, 1);
    addn(3, 1, -25, 1, 0,  0, 0, 0, 0, 1);
    addn(1, 1, -25, 1, 0,  1, 1, 0, 0, 0);             // fall event held
    addn(3, 1,  25, 0, 0,  1, 1, 0, 0, 0);             // stalled, fall stays
    addn(1, 1,  25, 1, 0,  1, 1, 1, 0, 1);             // replace with rise, no overflow
    addn(3, 1, -25, 1, 0,  0, 0, 0, 0, 1);
    addn(1, 1, -25, 1, 0,  1, 1, 0, 0, 0);
    addn(1, 0,   0, 1, 0,  0, 0, 0, 0, 0);
    addn(3, 1,  25, 0, 0,  0, 0, 0, 0, 0);
    addn(1, 1,  25, 0, 0,  1, 1, 1, 0, 1);             // rise held, consumer stalled
    addn(3, 1, -25, 0, 0,  1, 1, 1, 0, 1);
    addn(1, 1, -25, 0, 0,  1, 1, 1, 1, 0);             // fall dropped, overflow
    addn(1, 0,   0, 0, 0,  1, 1, 1, 1, 0);
    addn(1, 0,   0, 1, 0,  0, 0, 0, 1, 0);             // overflow is sticky
    addn(1, 1,  25, 1, 0,  0, 0, 0, 1, 0);             // gapped valid samples
    addn(1, 0,  25, 1, 0,  0, 0, 0, 1, 0);
    addn(1, 1,  25, 1, 0,  0, 0, 0, 1, 0);
    addn(1, 0,-100, 1, 0,  0, 0, 0, 1, 0);
    addn(1, 1,  25, 1, 0,  0, 0, 0, 1, 0);
    addn(1, 0,   0, 1, 0,  0, 0, 0, 1, 0);
    addn(1, 1,  25, 1, 0,  1, 1, 1, 1, 1);             // 4th valid sample commits

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Reset during RISE_PEND (cnt=2) with a falling event held in the slot.
    for (int i = 0; i < 3; i++) cyc($sformatf("rstseq_fall%0d", i), 1, -25, 1, 0, 0, 0, 0, 1, 1);
    cyc("rstseq_fall_commit", 1, -25, 1, 0, 1, 1, 0, 1, 0);
    cyc("rstseq_pend1", 1, 25, 0, 0, 1, 1, 0, 1, 0);
    cyc("rstseq_pend2", 1, 25, 0, 0, 1, 1, 0, 1, 0);
    cyc("rstseq_reset", 1, 25, 0, 1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc($sformatf("rstseq_post%0d", i), 1, 25, 1, 0, 0, 0, 0, 0, 0);
    cyc("rstseq_post_commit", 1, 25, 1, 0, 1, 1, 1, 0, 1, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
